// File: rtl/alu_pkg.sv
// Shared ALU encodings: operation types, control codes and requester IDs.
// Control codes are decoded per type, so R/I and branch codes may share values.
package alu_pkg;

    localparam logic [1:0] TYPE_RI = 2'b00;
    localparam logic [1:0] TYPE_S  = 2'b01;
    localparam logic [1:0] TYPE_B  = 2'b10;
    localparam logic [1:0] TYPE_J  = 2'b11;

    // R/I-type control codes
    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SUB  = 4'b0011;
    localparam logic [3:0] CTRL_XOR  = 4'b0100;
    localparam logic [3:0] CTRL_SLL  = 4'b0101;
    localparam logic [3:0] CTRL_SRL  = 4'b0110;
    localparam logic [3:0] CTRL_SRA  = 4'b0111;
    localparam logic [3:0] CTRL_SLT  = 4'b1000;
    localparam logic [3:0] CTRL_SLTU = 4'b1001;

    // Branch-type control codes; Zero reports "condition true"
    localparam logic [3:0] CTRL_BEQ  = 4'b0000;
    localparam logic [3:0] CTRL_BNE  = 4'b0001;
    localparam logic [3:0] CTRL_BLT  = 4'b0010;
    localparam logic [3:0] CTRL_BGE  = 4'b0011;
    localparam logic [3:0] CTRL_BLTU = 4'b0100;
    localparam logic [3:0] CTRL_BGEU = 4'b0101;

    localparam logic PORT_EX  = 1'b0;
    localparam logic PORT_AGU = 1'b1;

    typedef struct packed {
        logic [31:0] srca;
        logic [31:0] srcb;
        logic [3:0]  ctrl;
        logic [1:0]  typ;
    } alu_op_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// Request/result bundle between the two ALU requesters, the arbiter and the consumer.
interface alu_share_arb_if #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_srca;
    logic [31:0]      req0_srcb;
    logic [3:0]       req0_ctrl;
    logic [1:0]       req0_type;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_srca;
    logic [31:0]      req1_srcb;
    logic [3:0]       req1_ctrl;
    logic [1:0]       req1_type;
    logic [TAG_W-1:0] req1_tag;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             out_zero;
    logic             out_id;
    logic [TAG_W-1:0] out_tag;

    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;

    modport master (
        output req0_valid, req0_srca, req0_srcb, req0_ctrl, req0_type, req0_tag,
        input  req0_ready,
        output req1_valid, req1_srca, req1_srcb, req1_ctrl, req1_type, req1_tag,
        input  req1_ready,
        input  out_valid, out_result, out_zero, out_id, out_tag,
        output out_ready,
        input  grant_cnt0, grant_cnt1
    );

    modport slave (
        input  req0_valid, req0_srca, req0_srcb, req0_ctrl, req0_type, req0_tag,
        output req0_ready,
        input  req1_valid, req1_srca, req1_srcb, req1_ctrl, req1_type, req1_tag,
        output req1_ready,
        output out_valid, out_result, out_zero, out_id, out_tag,
        input  out_ready,
        output grant_cnt0, grant_cnt1
    );
endinterface

// File: rtl/alu.sv
// Single-cycle combinational ALU; S/J types compute srca+srcb, B types set Zero on condition true.
module ALU
    import alu_pkg::*;
(
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic [3:0]  alu_ctrl,
    input  logic [1:0]  alu_type,
    output logic [31:0] alu_result,
    output logic        zero
);
    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        alu_result = '0;
        zero       = 1'b0;
        case (alu_type)
            TYPE_RI: begin
                case (alu_ctrl)
                    CTRL_AND:  alu_result = srca & srcb;
                    CTRL_OR:   alu_result = srca | srcb;
                    CTRL_ADD:  alu_result = srca + srcb;
                    CTRL_SUB:  alu_result = srca - srcb;
                    CTRL_XOR:  alu_result = srca ^ srcb;
                    CTRL_SLL:  alu_result = srca << srcb[4:0];
                    CTRL_SRL:  alu_result = srca >> srcb[4:0];
                    CTRL_SRA:  alu_result = $unsigned($signed(srca) >>> srcb[4:0]);
                    CTRL_SLT:  alu_result = {31'b0, $signed(srca) < $signed(srcb)};
                    CTRL_SLTU: alu_result = {31'b0, srca < srcb};
                    default:   alu_result = '0;
                endcase
            end
            TYPE_S, TYPE_J: alu_result = srca + srcb;
            TYPE_B: begin
                case (alu_ctrl)
                    CTRL_BEQ:  zero = (srca == srcb);
                    CTRL_BNE:  zero = (srca != srcb);
                    CTRL_BLT:  zero = ($signed(srca) <  $signed(srcb));
                    CTRL_BGE:  zero = ($signed(srca) >= $signed(srcb));
                    CTRL_BLTU: zero = (srca <  srcb);
                    CTRL_BGEU: zero = (srca >= srcb);
                    default:   zero = 1'b0;
                endcase
            end
            default: begin
                alu_result = '0;
                zero       = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on conflict the port that did not win last time is chosen.
module rr_pick2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       any
);
    always_comb begin
        grant[0] = valid0 && (!valid1 || last_grant);
        grant[1] = valid1 && (!valid0 || !last_grant);
        any      = valid0 || valid1;
    end
endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between the execute stage (port 0) and the AGU (port 1), round-robin on
// conflict, with a one-entry registered result stage that honours consumer backpressure.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_share_arb_if.slave bus
);
    logic [1:0]       grant;
    logic             any_valid;
    logic             can_accept;
    logic             xfer;
    logic             sel_id;
    alu_op_t          op;
    logic [TAG_W-1:0] sel_tag;
    logic [31:0]      alu_result;
    logic             alu_zero;

    logic             out_valid_q,  out_valid_d;
    logic [31:0]      out_result_q, out_result_d;
    logic             out_zero_q,   out_zero_d;
    logic             out_id_q,     out_id_d;
    logic [TAG_W-1:0] out_tag_q,    out_tag_d;
    logic [CNT_W-1:0] cnt0_q,       cnt0_d;
    logic [CNT_W-1:0] cnt1_q,       cnt1_d;
    logic             last_grant_q, last_grant_d;

    rr_pick2 u_pick (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .any        (any_valid)
    );

    // The output slot frees up in the same cycle the consumer drains it.
    assign can_accept     = !out_valid_q || bus.out_ready;
    assign xfer           = any_valid && can_accept;
    assign sel_id         = grant[1] ? PORT_AGU : PORT_EX;
    assign bus.req0_ready = grant[0] && can_accept;
    assign bus.req1_ready = grant[1] && can_accept;

    always_comb begin
        if (sel_id == PORT_AGU) begin
            op.srca = bus.req1_srca;
            op.srcb = bus.req1_srcb;
            op.ctrl = bus.req1_ctrl;
            op.typ  = bus.req1_type;
            sel_tag = bus.req1_tag;
        end else begin
            op.srca = bus.req0_srca;
            op.srcb = bus.req0_srcb;
            op.ctrl = bus.req0_ctrl;
            op.typ  = bus.req0_type;
            sel_tag = bus.req0_tag;
        end
    end

    ALU u_alu (
        .srca       (op.srca),
        .srcb       (op.srcb),
        .alu_ctrl   (op.ctrl),
        .alu_type   (op.typ),
        .alu_result (alu_result),
        .zero       (alu_zero)
    );

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_zero_d   = out_zero_q;
        out_id_d     = out_id_q;
        out_tag_d    = out_tag_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        last_grant_d = last_grant_q;
        if (xfer) begin
            out_valid_d  = 1'b1;
            out_result_d = alu_result;
            out_zero_d   = alu_zero;
            out_id_d     = sel_id;
            out_tag_d    = sel_tag;
            last_grant_d = sel_id;
            if (sel_id == PORT_AGU) cnt1_d = cnt1_q + CNT_W'(1);
            else                    cnt0_d = cnt0_q + CNT_W'(1);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: all state, data registers included, is reset so a pending result is never
    // presented after reset; last_grant resets to port 1 so port 0 wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_zero_q   <= 1'b0;
            out_id_q     <= 1'b0;
            out_tag_q    <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            last_grant_q <= PORT_AGU;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_zero_q   <= out_zero_d;
            out_id_q     <= out_id_d;
            out_tag_q    <= out_tag_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_zero   = out_zero_q;
    assign bus.out_id     = out_id_q;
    assign bus.out_tag    = out_tag_q;
    assign bus.grant_cnt0 = cnt0_q;
    assign bus.grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: ALU vector table plus reset, conflict, backpressure
// and counter-wrap sequences, with the counters built narrow so wrap is reachable.
module tb_alu_share_arb;

    localparam int TAG_W = 4;
    localparam int CNT_W = 4;

    typedef struct {
        bit          port;
        logic [31:0] srca;
        logic [31:0] srcb;
        logic [3:0]  ctrl;
        logic [1:0]  typ;
        logic [3:0]  tag;
        logic [31:0] exp_result;
        logic        exp_zero;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt0 = 0;
    int   exp_cnt1 = 0;
    vec_t vec[19];

    alu_share_arb_if #(.TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

    alu_share_arb #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.req0_valid = 1'b0; bus.req0_srca = '0; bus.req0_srcb = '0;
        bus.req0_ctrl  = '0;   bus.req0_type = '0; bus.req0_tag  = '0;
        bus.req1_valid = 1'b0; bus.req1_srca = '0; bus.req1_srcb = '0;
        bus.req1_ctrl  = '0;   bus.req1_type = '0; bus.req1_tag  = '0;
    endtask

    task automatic drive(input bit port, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c, input logic [1:0] t, input logic [3:0] tag);
        if (port) begin
            bus.req1_valid = 1'b1; bus.req1_srca = a; bus.req1_srcb = b;
            bus.req1_ctrl  = c;    bus.req1_type = t; bus.req1_tag  = tag;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_srca = a; bus.req0_srcb = b;
            bus.req0_ctrl  = c;    bus.req0_type = t; bus.req0_tag  = tag;
        end
    endtask

    function automatic vec_t mk(input bit p, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] c, input logic [1:0] t, input logic [3:0] tag,
                                input logic [31:0] r, input logic z);
        vec_t v;
        v.port = p; v.srca = a; v.srcb = b; v.ctrl = c; v.typ = t; v.tag = tag;
        v.exp_result = r; v.exp_zero = z;
        return v;
    endfunction

    task automatic check_out(input string name, input logic v, input logic [31:0] r,
                             input logic z, input logic id, input logic [3:0] tag);
        check({name, "_valid"},  32'(bus.out_valid), 32'(v));
        check({name, "_result"}, bus.out_result, r);
        check({name, "_zero"},   32'(bus.out_zero), 32'(z));
        check({name, "_id"},     32'(bus.out_id), 32'(id));
        check({name, "_tag"},    32'(bus.out_tag), 32'(tag));
    endtask

    task automatic check_cnts(input string name);
        check({name, "_cnt0"}, 32'(bus.grant_cnt0), 32'(exp_cnt0 % 16));
        check({name, "_cnt1"}, 32'(bus.grant_cnt1), 32'(exp_cnt1 % 16));
    endtask

    initial begin
        vec[0]  = mk(0, 32'h7FFF_FFFF, 32'h1,         4'b0010, 2'b00, 4'd5,  32'h8000_0000, 1'b0);
        vec[1]  = mk(1, 32'h0,         32'h1,         4'b0011, 2'b00, 4'd1,  32'hFFFF_FFFF, 1'b0);
        vec[2]  = mk(0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 2'b00, 4'd2,  32'hF000_F000, 1'b0);
        vec[3]  = mk(1, 32'h0F,        32'hF0,        4'b0001, 2'b00, 4'd3,  32'hFF,        1'b0);
        vec[4]  = mk(0, 32'hFFFF_0000, 32'h0FF0_0FF0, 4'b0100, 2'b00, 4'd4,  32'hF00F_0FF0, 1'b0);
        vec[5]  = mk(0, 32'h1,         32'h23,        4'b0101, 2'b00, 4'd6,  32'h8,         1'b0);
        vec[6]  = mk(1, 32'h8000_0000, 32'h4,         4'b0110, 2'b00, 4'd7,  32'h0800_0000, 1'b0);
        vec[7]  = mk(0, 32'h8000_0000, 32'h4,         4'b0111, 2'b00, 4'd8,  32'hF800_0000, 1'b0);
        vec[8]  = mk(0, 32'hFFFF_FFFF, 32'h1,         4'b1000, 2'b00, 4'd9,  32'h1,         1'b0);
        vec[9]  = mk(1, 32'hFFFF_FFFF, 32'h1,         4'b1001, 2'b00, 4'd10, 32'h0,         1'b0);
        vec[10] = mk(0, 32'h1234_5678, 32'h1,         4'b1111, 2'b00, 4'd11, 32'h0,         1'b0);
        vec[11] = mk(1, 32'h1000,      32'h20,        4'b0000, 2'b01, 4'd12, 32'h1020,      1'b0);
        vec[12] = mk(1, 32'h2000,      32'hFFFF_FFFC, 4'b0000, 2'b11, 4'd13, 32'h1FFC,      1'b0);
        vec[13] = mk(0, 32'h5,         32'h5,         4'b0000, 2'b10, 4'd14, 32'h0,         1'b1);
        vec[14] = mk(0, 32'h5,         32'h5,         4'b0001, 2'b10, 4'd15, 32'h0,         1'b0);
        vec[15] = mk(1, 32'hFFFF_FFFF, 32'h1,         4'b0010, 2'b10, 4'd1,  32'h0,         1'b1);
        vec[16] = mk(1, 32'hFFFF_FFFF, 32'h1,         4'b0100, 2'b10, 4'd2,  32'h0,         1'b0);
        vec[17] = mk(0, 32'h1,         32'hFFFF_FFFF, 4'b0011, 2'b10, 4'd3,  32'h0,         1'b1);
        vec[18] = mk(1, 32'h1,         32'hFFFF_FFFF, 4'b0101, 2'b10, 4'd4,  32'h0,         1'b0);

        rst_n = 1'b0;
        clear_reqs();
        bus.out_ready = 1'b0;
        tick();
        tick();
        check_out("reset", 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        check_cnts("reset");
        rst_n = 1'b1;

        // Load the output stage, then reset between edges while it is held
        drive(0, 32'd3, 32'd4, 4'b0010, 2'b00, 4'd9);
        tick();
        exp_cnt0++;
        check_out("preload", 1'b1, 32'd7, 1'b0, 1'b0, 4'd9);
        bus.req0_valid = 1'b0;
        drive(1, 32'd8, 32'd1, 4'b0011, 2'b00, 4'd2);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        check_out("async_rst", 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        check_cnts("async_rst");
        tick();
        rst_n = 1'b1;

        // Conflict: both valid for 4 cycles, grants must alternate starting at port 0
        clear_reqs();
        drive(0, 32'd100, 32'd1, 4'b0010, 2'b00, 4'd1);
        drive(1, 32'd100, 32'd1, 4'b0011, 2'b00, 4'd2);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("conf%0d_rdy0", k), 32'(bus.req0_ready), 32'(k % 2 == 0));
            check($sformatf("conf%0d_rdy1", k), 32'(bus.req1_ready), 32'(k % 2 == 1));
            tick();
            if (k % 2 == 0) begin
                exp_cnt0++;
                check_out($sformatf("conf%0d", k), 1'b1, 32'd101, 1'b0, 1'b0, 4'd1);
            end else begin
                exp_cnt1++;
                check_out($sformatf("conf%0d", k), 1'b1, 32'd99, 1'b0, 1'b1, 4'd2);
            end
        end
        check("conf_cnt0", 32'(bus.grant_cnt0), 32'd2);
        check("conf_cnt1", 32'(bus.grant_cnt1), 32'd2);

        // Backpressure: port 0 result sits while both ports wait; port 1 owns priority
        clear_reqs();
        drive(0, 32'd10, 32'd20, 4'b0010, 2'b00, 4'd3);
        tick();
        exp_cnt0++;
        check_out("bp_load", 1'b1, 32'd30, 1'b0, 1'b0, 4'd3);
        bus.out_ready = 1'b0;
        drive(0, 32'd1, 32'd1, 4'b0010, 2'b00, 4'd4);
        drive(1, 32'd50, 32'd8, 4'b0011, 2'b00, 4'd6);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d_rdy0", k), 32'(bus.req0_ready), 32'd0);
            check($sformatf("bp%0d_rdy1", k), 32'(bus.req1_ready), 32'd0);
            tick();
            check_out($sformatf("bp%0d_hold", k), 1'b1, 32'd30, 1'b0, 1'b0, 4'd3);
            check_cnts($sformatf("bp%0d", k));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_rdy0", 32'(bus.req0_ready), 32'd0);
        check("bp_rel_rdy1", 32'(bus.req1_ready), 32'd1);
        tick();
        exp_cnt1++;
        check_out("bp_refill", 1'b1, 32'd42, 1'b0, 1'b1, 4'd6);
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check("bp_next_rdy0", 32'(bus.req0_ready), 32'd1);
        tick();
        exp_cnt0++;
        check_out("bp_next", 1'b1, 32'd2, 1'b0, 1'b0, 4'd4);
        check_cnts("bp_end");

        // ALU vector table, one port active per vector
        for (int i = 0; i < 19; i++) begin
            clear_reqs();
            drive(vec[i].port, vec[i].srca, vec[i].srcb, vec[i].ctrl, vec[i].typ, vec[i].tag);
            @(negedge clk);
            check($sformatf("vec%0d_rdy0", i), 32'(bus.req0_ready), 32'(vec[i].port == 1'b0));
            check($sformatf("vec%0d_rdy1", i), 32'(bus.req1_ready), 32'(vec[i].port == 1'b1));
            tick();
            if (vec[i].port) exp_cnt1++;
            else             exp_cnt0++;
            check_out($sformatf("vec%0d", i), 1'b1, vec[i].exp_result, vec[i].exp_zero,
                      vec[i].port, vec[i].tag);
        end
        check_cnts("table");

        // Drain with nothing pending: valid drops, data registers keep last value
        clear_reqs();
        tick();
        check_out("drain", 1'b0, vec[18].exp_result, vec[18].exp_zero, 1'b1, vec[18].tag);

        // Counter wrap: 17 port-0 transfers into a 4-bit counter
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        drive(0, 32'd1, 32'd1, 4'b0010, 2'b00, 4'd7);
        for (int k = 0; k < 17; k++) begin
            tick();
            exp_cnt0++;
        end
        clear_reqs();
        check("wrap_cnt0", 32'(bus.grant_cnt0), 32'd1);
        check("wrap_cnt1", 32'(bus.grant_cnt1), 32'd0);
        check_cnts("wrap_model");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and result register for the core's single combinational ALU. The execute stage (port 0) and the address/branch-target unit (port 1) each present ALU operations on a valid/ready handshake. One operation per cycle is granted, round-robin on conflict, and evaluated by the instantiated `ALU`. The result, Zero flag, requester ID and tag are registered into a one-entry output stage with backpressure.

## Interface
- `TAG_W`, default 4: width of the opaque tag carried with each operation.
- `CNT_W`, default 16: width of the per-port grant counters.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req0_valid`, `req1_valid`  in  1 each: operation present.
- `req0_ready`, `req1_ready`  out  1 each: operation accepted this cycle.
- `reqN_srca`, `reqN_srcb`  in  32 each: operands for port N.
- `reqN_ctrl`  in  4: ALU control code for port N.
- `reqN_type`  in  2: ALU type for port N (00 R/I, 01 S, 10 B, 11 J).
- `reqN_tag`  in  `TAG_W`: tag for port N, returned with the result.
- `out_valid`  out  1: result register holds a result.
- `out_ready`  in  1: consumer takes the result.
- `out_result`  out  32: registered ALU result.
- `out_zero`  out  1: registered Zero flag. Meaningful only for type 10.
- `out_id`  out  1: port that issued the operation.
- `out_tag`  out  `TAG_W`: tag of the operation.
- `grant_cnt0`, `grant_cnt1`  out  `CNT_W` each: accepted-operation counters.

## Operation
- **Handshake.** Valid/ready on every interface. A transfer occurs when valid && ready on the same rising edge. Once a requester asserts valid, it holds valid and its payload stable until ready. `out_*` holds stable while out_valid && !out_ready.
- **Capacity.** `can_accept = !out_valid || out_ready`.
- **Grant.**
  - Only req0 valid: port 0 is granted.
  - Only req1 valid: port 1 is granted.
  - Both valid: the port ≠ `last_grant` is granted.
  - `reqN_ready = grant_N && can_accept`, and it depends combinationally on `out_ready`.
  - At most one ready is high per cycle.
  - A ready is never asserted to a port whose valid is low.
- **Round-robin.** `last_grant` updates to the granted port only on an accepted transfer. A stalled grant does not rotate priority.
- **Datapath.** The granted port's srca/srcb/ctrl/type drive the ALU.
  - On transfer: `out_result <= ALUResult`, `out_zero <= Zero`, `out_id <= granted port`, `out_tag <= tag`, `out_valid <= 1`.
  - Results are bit-exact ALU semantics: 32-bit wrap on add/sub, shift amount from srcb[4:0], result 0 and Zero 0 for undefined codes.
- **Output valid.** If out_valid && out_ready with no new transfer, `out_valid <= 0`. Data registers keep their last value.
- **Counters.** `grant_cntN` increments on each port-N transfer and wraps modulo 2^`CNT_W`.
- **Reset.** Reset is asynchronous and may arrive mid-operation. A pending output is discarded; no partial result is ever presented.
  - out_valid, out_result, out_zero, out_id, out_tag: 0.
  - grant_cnt0, grant_cnt1: 0.
  - `last_grant`: 1, so port 0 wins the first conflict.

## Timing
- Latency is 1 cycle: a result accepted at edge k is visible on `out_*` after edge k, with out_valid high.
- Throughput is 1 operation per cycle while `out_ready` stays high, including a simultaneous drain and refill of the output register.
- With `out_ready` held low and out_valid high, both reqN_ready are low and all state is frozen.
- No combinational path from reqN_valid to out_*. A path from out_ready to reqN_ready is permitted.

## Structure
- Shared package `alu_pkg`:
  - ALUType constants: TYPE_RI=2'b00, TYPE_S=2'b01, TYPE_B=2'b10, TYPE_J=2'b11.
  - ALU control code constants (ADD=0010, SUB=0011, … BGEU=0101).
  - Port-ID constants PORT_EX=0, PORT_AGU=1.
- Sub-modules:
  - `rr_pick2`: 2-way round-robin pick from (valid0, valid1, last_grant). Outputs grant vector and `any`.
  - The existing `ALU`, instantiated once.

## Test plan
- **Reset.** Assert rst_n=0 mid-transfer with out_valid=1. Required: out_valid=0, counters=0 immediately, asynchronous to clk. After release, req0 and req1 both valid: port 0 is granted first.
- **Single port.** req0 ADD 0x7FFFFFFF+1 (type 00, ctrl 0010), tag 5, out_ready=1. Required, next cycle: out_result=0x80000000, out_id=0, out_tag=5.
- **Conflict.** Both ports valid for 4 cycles, out_ready=1. Required:
  - grants alternate 0,1,0,1;
  - grant_cnt0=2, grant_cnt1=2;
  - results return in grant order with correct ids.
- **Backpressure.** out_ready=0 for 3 cycles with out_valid=1. Required: both readies low and out_* stable. Then raise out_ready together with a pending req1: drain and refill occur in the same cycle, and `last_grant` does not rotate during the stall.
- **Branch flag.** req1 type 10, ctrl 0010 (BLT), srca=0xFFFFFFFF, srcb=1. Required: out_zero=1, out_result=0. With ctrl 0100 (BLTU): out_zero=0.
- **Counter wrap.** CNT_W=4, 17 port-0 transfers. Required: grant_cnt0=1.
